// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the memory port controller.
// Included by the top-level controller and by the store byte sequencer.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_e;

  typedef enum logic {
    REQ_IF,
    REQ_D
  } req_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Sizes 2 and 3 both mean a full word.
  function automatic logic [2:0] bytes_of(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_store_seq.sv
// Byte sequencer for stores: walks the latched store address upward and emits
// the store data most-significant byte first, flagging the final byte.
module mem_store_seq
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic [31:0]       wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              last_byte
);

  logic [1:0] cnt_q, cnt_d;
  logic [2:0] nbytes;
  logic [1:0] last_idx;
  logic [1:0] byte_sel;

  always_comb begin
    nbytes    = bytes_of(size);
    last_idx  = 2'(nbytes - 3'd1);
    byte_sel  = last_idx - cnt_q;
    last_byte = active && (cnt_q == last_idx);
    // Address arithmetic wraps naturally at the top of memory.
    mem_addr  = addr + ADDR_W'(cnt_q);
    mem_wdata = wdata[{byte_sel, 3'b000} +: 8];
    cnt_d     = cnt_q;
    if (!active || last_byte) begin
      cnt_d = 2'd0;
    end else begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Arbiter and sequencer sharing one byte-addressed memory port between the
// instruction-fetch and load/store requesters, with bounded fetch starvation.
module mem_port_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned StarveW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  state_e              state_q, state_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic [31:0]         wdata_q, wdata_d;
  req_e                req_q, req_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         d_rdata_q, d_rdata_d;

  logic                fetch_wins;
  logic                seq_active;
  logic [ADDR_W-1:0]   seq_addr;
  logic [7:0]          seq_wdata;
  logic                seq_last;

  mem_store_seq #(
    .ADDR_W(ADDR_W)
  ) u_store_seq (
    .clk      (clk),
    .rst      (rst),
    .active   (seq_active),
    .addr     (addr_q),
    .size     (size_q),
    .wdata    (wdata_q),
    .mem_addr (seq_addr),
    .mem_wdata(seq_wdata),
    .last_byte(seq_last)
  );

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    req_d       = req_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = 8'h00;
    seq_active  = 1'b0;

    // Data has priority unless fetch has already waited STARVE_MAX data grants.
    fetch_wins = if_req && (!d_req || (starve_q == StarveW'(STARVE_MAX)));

    unique case (state_q)
      IDLE: begin
        if (!rst) begin
          if (fetch_wins) begin
            if_gnt  = 1'b1;
            addr_d  = if_addr;
            size_d  = SZ_W;
            wdata_d = 32'h0;
            req_d   = REQ_IF;
            state_d = RD;
          end else if (d_req) begin
            d_gnt   = 1'b1;
            addr_d  = d_addr;
            size_d  = d_size;
            wdata_d = d_wdata;
            req_d   = REQ_D;
            state_d = d_we ? WR : RD;
          end
        end
      end
      RD: begin
        mem_addr = addr_q;
        if (req_q == REQ_IF) begin
          if_rdata_d  = mem_rdata;
          if_rvalid_d = 1'b1;
        end else begin
          d_rdata_d  = mem_rdata;
          d_rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end
      WR: begin
        seq_active = 1'b1;
        mem_addr   = seq_addr;
        mem_wdata  = seq_wdata;
        // A reset in this cycle aborts the store before this byte lands.
        mem_we     = !rst;
        if (seq_last) begin
          d_rvalid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!if_req || if_gnt) begin
      starve_d = '0;
    end else if (d_gnt) begin
      starve_d = starve_q + StarveW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      addr_q      <= '0;
      size_q      <= SZ_B;
      wdata_q     <= 32'h0;
      req_q       <= REQ_IF;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      req_q       <= req_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
